// File: rtl/guitar_strum_sequencer.sv
// guitar_strum_sequencer
// Turns keyboard keycode press events into one-cycle per-string pluck pulses.
// Single-string keys pluck immediately; chord keys are strummed one string at
// a time, STRUM_GAP cycles apart, by a small IDLE/PULSE/WAIT state machine.
// Optional feature macro: STRUM_ALT_EN (alternates down/up strums on every
// chord event). Without it every strum is a down strum (string 6 first).
module guitar_strum_sequencer #(
    parameter int STRUM_GAP = 50000,
    parameter int GAP_W     = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] note,
    output logic [6:0] pluck,
    output logic [4:0] pflag,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STRUM_GAP - 1);

    logic [7:0]       note_q;
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] next_cnt;
    logic [2:0]       str_idx;
    logic [2:0]       next_idx;
    logic [6:0]       str_mask;
    logic [6:0]       next_mask;

    logic [4:0]       key_code;
    logic [6:0]       key_str;
    logic [6:0]       key_chord;
    logic             new_event;
    logic             chord_evt;

    logic             cur_up;
    logic             start_up;
    logic [2:0]       end_idx;
    logic [2:0]       step_idx;
    logic [2:0]       start_idx;

    // Lowest string present in a mask (strings live in bits 1..6).
    function automatic logic [2:0] lowest_str(input logic [6:0] m);
        lowest_str = 3'd0;
        for (int i = 6; i >= 1; i--) begin
            if (m[i]) lowest_str = 3'(i);
        end
    endfunction

    // Highest string present in a mask.
    function automatic logic [2:0] highest_str(input logic [6:0] m);
        highest_str = 3'd0;
        for (int i = 1; i <= 6; i++) begin
            if (m[i]) highest_str = 3'(i);
        end
    endfunction

    // Next string in the mask below idx (idx itself if none).
    function automatic logic [2:0] next_lower(input logic [6:0] m, input logic [2:0] idx);
        next_lower = idx;
        for (int i = 1; i <= 6; i++) begin
            if (m[i] && (3'(i) < idx)) next_lower = 3'(i);
        end
    endfunction

    // Next string in the mask above idx (idx itself if none).
    function automatic logic [2:0] next_higher(input logic [6:0] m, input logic [2:0] idx);
        next_higher = idx;
        for (int i = 6; i >= 1; i--) begin
            if (m[i] && (3'(i) > idx)) next_higher = 3'(i);
        end
    endfunction

    // Keycode decode: string keys give a one-hot string, chord keys a mask.
    always_comb begin
        key_code  = 5'd0;
        key_str   = 7'b0000000;
        key_chord = 7'b0000000;
        case (note)
            8'd9:    begin key_code = 5'd1;  key_str   = 7'b0000010; end
            8'd10:   begin key_code = 5'd2;  key_str   = 7'b0000100; end
            8'd11:   begin key_code = 5'd3;  key_str   = 7'b0001000; end
            8'd13:   begin key_code = 5'd4;  key_str   = 7'b0010000; end
            8'd14:   begin key_code = 5'd5;  key_str   = 7'b0100000; end
            8'd15:   begin key_code = 5'd6;  key_str   = 7'b1000000; end
            8'd6:    begin key_code = 5'd7;  key_chord = 7'b1111110; end
            8'd8:    begin key_code = 5'd8;  key_chord = 7'b1111110; end
            8'd4:    begin key_code = 5'd9;  key_chord = 7'b1111100; end
            8'd7:    begin key_code = 5'd10; key_chord = 7'b1111000; end
            default: begin key_code = 5'd0; end
        endcase
    end

    // A press is a change of keycode onto a valid code; holding never retriggers.
    assign new_event = (note != note_q) && (key_code != 5'd0);
    assign chord_evt = new_event && (key_chord != 7'b0000000);

`ifdef STRUM_ALT_EN
    logic dir_toggle;
    logic strum_up;

    // Direction toggle flips on every chord press; the active strum keeps its own direction.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dir_toggle <= 1'b0;
            strum_up   <= 1'b0;
        end else if (chord_evt) begin
            dir_toggle <= ~dir_toggle;
            strum_up   <= dir_toggle;
        end
    end

    assign cur_up   = strum_up;
    assign start_up = dir_toggle;
`else
    assign cur_up   = 1'b0;
    assign start_up = 1'b0;
`endif

    assign end_idx   = cur_up ? highest_str(str_mask) : lowest_str(str_mask);
    assign step_idx  = cur_up ? next_higher(str_mask, str_idx) : next_lower(str_mask, str_idx);
    assign start_idx = start_up ? lowest_str(key_chord) : highest_str(key_chord);

    // Strum sequencing; a chord press always (re)starts a strum and drops the old one.
    always_comb begin
        next_state = state;
        next_cnt   = gap_cnt;
        next_idx   = str_idx;
        next_mask  = str_mask;
        case (state)
            PULSE: begin
                if (str_idx == end_idx) begin
                    next_state = IDLE;
                end else if (STRUM_GAP == 1) begin
                    next_state = PULSE;
                    next_idx   = step_idx;
                end else begin
                    next_state = WAIT;
                    next_cnt   = GAP_LOAD;
                end
            end
            WAIT: begin
                next_cnt = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1)) begin
                    next_state = PULSE;
                    next_idx   = step_idx;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (chord_evt) begin
            next_state = PULSE;
            next_mask  = key_chord;
            next_idx   = start_idx;
        end
    end

    // State registers plus registered outputs, so every pulse lands one cycle after its cause.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            note_q   <= 8'd0;
            state    <= IDLE;
            gap_cnt  <= '0;
            str_idx  <= 3'd0;
            str_mask <= 7'b0000000;
            pluck    <= 7'b0000000;
            pflag    <= 5'd0;
            busy     <= 1'b0;
        end else begin
            note_q   <= note;
            state    <= next_state;
            gap_cnt  <= next_cnt;
            str_idx  <= next_idx;
            str_mask <= next_mask;
            pluck    <= (new_event ? key_str : 7'b0000000)
                      | ((next_state == PULSE) ? (7'd1 << next_idx) : 7'b0000000);
            busy     <= (next_state != IDLE);
            if (new_event) begin
                pflag <= key_code;
            end
        end
    end

endmodule

// File: tb/tb_guitar_strum_sequencer.sv
// tb_guitar_strum_sequencer
// Directed bench for guitar_strum_sequencer with STRUM_GAP=4. A schedule
// model pushes expected pulses into a scoreboard queue when a key event is
// driven; each cycle the due entries are popped and compared to pluck.
// Honours STRUM_ALT_EN the same way the design does.
module tb_guitar_strum_sequencer;

    localparam int GAP = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] note;
    logic [6:0] pluck;
    logic [4:0] pflag;
    logic       busy;

    guitar_strum_sequencer #(.STRUM_GAP(GAP), .GAP_W(20)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .note  (note),
        .pluck (pluck),
        .pflag (pflag),
        .busy  (busy)
    );

    // Free-running clock and cycle counter used to timestamp scheduled pulses.
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [6:0] bits;
        bit         strum;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         passes = 0;
    logic [7:0] prev_note = 8'd0;
    logic [4:0] exp_pflag = 5'd0;
    int         busy_from = -1;
    int         busy_to   = -2;
    bit         alt_dir   = 1'b0;

    function automatic logic [4:0] code_of(input logic [7:0] v);
        case (v)
            8'd9:  return 5'd1;
            8'd10: return 5'd2;
            8'd11: return 5'd3;
            8'd13: return 5'd4;
            8'd14: return 5'd5;
            8'd15: return 5'd6;
            8'd6:  return 5'd7;
            8'd8:  return 5'd8;
            8'd4:  return 5'd9;
            8'd7:  return 5'd10;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [6:0] chord_mask(input logic [4:0] c);
        case (c)
            5'd7, 5'd8: return 7'b1111110;
            5'd9:       return 7'b1111100;
            5'd10:      return 7'b1111000;
            default:    return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, expv);
    endtask

    // Reference behaviour: schedule the pulses a key change should produce.
    task automatic model_event(input logic [7:0] v);
        logic [4:0] c;
        logic [6:0] m;
        int         t;
        int         n;
        bit         up;
        c = code_of(v);
        t = cyc;
        if ((v != prev_note) && (c != 5'd0)) begin
            exp_pflag = c;
            if (c <= 5'd6) begin
                sb.push_back('{due: t + 1, bits: 7'(1 << int'(c)), strum: 1'b0});
            end else begin
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].strum && sb[i].due >= t + 1) sb.delete(i);
                end
                m  = chord_mask(c);
                up = 1'b0;
`ifdef STRUM_ALT_EN
                up      = alt_dir;
                alt_dir = ~alt_dir;
`endif
                n = 0;
                for (int k = 0; k < 6; k++) begin
                    int s;
                    s = up ? (k + 1) : (6 - k);
                    if (m[s]) begin
                        sb.push_back('{due: t + 1 + n * GAP, bits: 7'(1 << s), strum: 1'b1});
                        n++;
                    end
                end
                busy_from = t + 1;
                busy_to   = t + 1 + (n - 1) * GAP;
            end
        end
        prev_note = v;
    endtask

    task automatic checkOutput();
        logic [6:0] exp_bits;
        exp_bits = 7'b0000000;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                exp_bits |= sb[i].bits;
                sb.delete(i);
            end
        end
        chk("pluck", 32'(pluck), 32'(exp_bits));
        chk("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc <= busy_to)));
        chk("pflag", 32'(pflag), 32'(exp_pflag));
    endtask

    task automatic applyStimulus(input logic [7:0] v);
        note = v;
        model_event(v);
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    task automatic hold(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) applyStimulus(v);
    endtask

    task automatic mid_reset();
        #2;
        note = 8'd0;
        Reset = 1'b1;
        sb.delete();
        prev_note = 8'd0;
        exp_pflag = 5'd0;
        busy_from = -1;
        busy_to   = -2;
        alt_dir   = 1'b0;
        #1;
        chk("rst_pluck", 32'(pluck), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pflag", 32'(pflag), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // Directed sequence covering single strings, chords, abort, overlap and reset.
    initial begin
        Reset = 1'b1;
        note  = 8'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("init_pluck", 32'(pluck), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_pflag", 32'(pflag), 32'd0);
        Reset = 1'b0;
        hold(2, 8'd0);

        $display("[TB] single string F held");
        hold(3, 8'd9);
        hold(4, 8'd0);

        $display("[TB] C chord down strum");
        hold(26, 8'd6);
        hold(4, 8'd0);

        $display("[TB] D chord, strings 6..3");
        hold(18, 8'd7);
        hold(4, 8'd0);

        $display("[TB] E chord aborted by A chord");
        hold(6, 8'd8);
        hold(24, 8'd4);
        hold(4, 8'd0);

        $display("[TB] C chord with L pressed on a strum pulse");
        hold(4, 8'd6);
        hold(22, 8'd15);
        hold(4, 8'd0);

        $display("[TB] invalid codes");
        applyStimulus(8'd5);
        applyStimulus(8'd255);
        applyStimulus(8'd12);
        applyStimulus(8'd0);
        applyStimulus(8'd10);
        applyStimulus(8'd3);
        hold(3, 8'd0);

        $display("[TB] reset in the middle of a strum");
        hold(7, 8'd6);
        applyStimulus(8'd0);
        mid_reset();
        hold(30, 8'd0);

        $display("[TB] two consecutive C presses");
        hold(2, 8'd6);
        hold(24, 8'd0);
        hold(2, 8'd6);
        hold(24, 8'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
